ps2_scan_ctrl: RTL and testbench

//  Sequences the byte stream from the PS/2 receiver into complete key events.

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_evt_fifo.sv | 67 ++++++
 rtl/ps2_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, FSM state encoding and event record layout
// for the scan sequencer and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int EV_W = 10;

  // Pause is E1 followed by seven more bytes that carry no extra information
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous event FIFO; an occupancy counter drives full/empty and a
// sticky overflow flag records pushes dropped while full.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int EV_W  = ps2_pkg::EV_W
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clr_ovf_i,
  input  logic [EV_W-1:0] din_i,
  output logic [EV_W-1:0] dout_o,
  output logic            valid_o,
  output logic            full_o,
  output logic            ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EV_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            do_push, do_pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
  always_comb begin
    do_pop   = pop_i && !empty;
    do_push  = push_i && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (push_i && full && !do_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign full_o  = full;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: turns receiver bytes into {ext,brk,code} key events.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the held key.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic       clk_nexys,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       fifo_full,
  output logic       ovf,
  output logic       seq_err
);

  localparam int              TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seq_err_q, seq_err_d;
  logic          timeout;
  logic          raw_push, raw_pause, fifo_push;
  ps2_ev_t       raw_ev, head_ev;

  // A stalled partial sequence is abandoned unless a byte arrives on the deadline cycle
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    seq_err_d = 1'b0;
    raw_push  = 1'b0;
    raw_pause = 1'b0;
    raw_ev    = '0;
    timeout   = (state_q != ST_IDLE) && !rx_done_tick && (tmo_q == TMO_LAST);
    if (timeout) begin
      state_d   = ST_IDLE;
      seq_err_d = 1'b1;
    end else if (rx_done_tick) begin
      raw_ev.code = rx_byte;
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (rx_byte == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (!is_status_byte(rx_byte)) begin
            raw_push = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            raw_ev.ext = 1'b1;
            raw_push   = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK: begin
          raw_ev.brk = 1'b1;
          raw_push   = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_EXT_BRK: begin
          raw_ev.ext = 1'b1;
          raw_ev.brk = 1'b1;
          raw_push   = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip_q == 3'd1) begin
            raw_ev.code = PS2_PAUSE;
            raw_pause   = 1'b1;
            raw_push    = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    tmo_d = ((state_d == ST_IDLE) || rx_done_tick) ? '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_vld_q, held_vld_d;
  logic [8:0] held_q, held_d;

  // Pause never sends a break, so it is kept out of the held-key tracking
  always_comb begin
    held_vld_d = held_vld_q;
    held_d     = held_q;
    fifo_push  = raw_push;
    if (raw_push && !raw_pause) begin
      if (raw_ev.brk) begin
        if (held_vld_q && (held_q == {raw_ev.ext, raw_ev.code})) held_vld_d = 1'b0;
      end else if (held_vld_q && (held_q == {raw_ev.ext, raw_ev.code})) begin
        fifo_push = 1'b0;
      end else begin
        held_vld_d = 1'b1;
        held_d     = {raw_ev.ext, raw_ev.code};
      end
    end
  end

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      held_vld_q <= 1'b0;
      held_q     <= '0;
    end else begin
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
    end
  end
`else
  assign fifo_push = raw_push;
`endif

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .EV_W  (EV_W)
  ) u_fifo (
    .clk_i     (clk_nexys),
    .reset_i   (reset),
    .push_i    (fifo_push),
    .pop_i     (rd_en),
    .clr_ovf_i (clr_ovf),
    .din_i     (raw_ev),
    .dout_o    (head_ev),
    .valid_o   (ev_valid),
    .full_o    (fifo_full),
    .ovf_o     (ovf)
  );

  assign ev_code = head_ev.code;
  assign ev_ext  = head_ev.ext;
  assign ev_brk  = head_ev.brk;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: vector table, corner-case sequences and a
// randomized event stream scored against a queue model of the event FIFO.
module tb_ps2_scan_ctrl;

  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 50;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxDone = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       rdEn = 1'b0;
  logic       clrOvf = 1'b0;
  logic       evValid, evExt, evBrk, fifoFull, ovfOut, seqErr;
  logic [7:0] evCode;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_nexys    (clk),
    .reset        (reset),
    .rx_done_tick (rxDone),
    .rx_byte      (rxByte),
    .rd_en        (rdEn),
    .clr_ovf      (clrOvf),
    .ev_valid     (evValid),
    .ev_code      (evCode),
    .ev_ext       (evExt),
    .ev_brk       (evBrk),
    .fifo_full    (fifoFull),
    .ovf          (ovfOut),
    .seq_err      (seqErr)
  );

  typedef struct {
    int         nBytes;
    logic [7:0] bytes [8];
    int         nEv;
    logic [9:0] evs [2];
  } vecT;

  typedef struct {
    logic [7:0] b;
    bit         hasEv;
    bit         pause;
    logic [9:0] ev;
  } streamT;

  int         checks = 0;
  int         errors = 0;
  vecT        vecs [8];
  streamT     stream [$];
  logic [9:0] modelQ [$];
  logic [9:0] typExp [$];
  bit         modelOvf;
  bit         heldValid;
  logic [8:0] heldKey;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic pop);
    rxDone = 1'b1;
    rxByte = b;
    rdEn   = pop;
    tick();
    rxDone = 1'b0;
    rdEn   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0);
    tick();
    tick();
  endtask

  task automatic doReset();
    reset  = 1'b1;
    rxDone = 1'b0;
    rdEn   = 1'b0;
    clrOvf = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    modelQ.delete();
    modelOvf  = 1'b0;
    heldValid = 1'b0;
    heldKey   = '0;
  endtask

  task automatic popExpect(input string name, input logic [9:0] exp);
    checkOutput({name, "_valid"}, evValid, 1);
    checkOutput(name, {evExt, evBrk, evCode}, exp);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
  endtask

  // Held-key auto-repeat suppression as seen from the event level
  task automatic modelFilter(input logic [9:0] ev, input bit pause, output bit keep);
    keep = 1'b1;
    if (FILTER_EN && !pause) begin
      if (ev[8]) begin
        if (heldValid && heldKey == {ev[9], ev[7:0]}) heldValid = 1'b0;
      end else if (heldValid && heldKey == {ev[9], ev[7:0]}) begin
        keep = 1'b0;
      end else begin
        heldValid = 1'b1;
        heldKey   = {ev[9], ev[7:0]};
      end
    end
  endtask

  task automatic addByte(input logic [7:0] b, input bit hasEv, input bit pause,
                         input logic [9:0] ev);
    streamT s;
    s.b = b; s.hasEv = hasEv; s.pause = pause; s.ev = ev;
    stream.push_back(s);
  endtask

  task automatic addItem();
    logic [7:0] code;
    logic [7:0] statusBytes [5];
    int kind;
    statusBytes = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
    code = 8'($urandom_range(8'h10, 8'h17));
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1, 2: addByte(code, 1, 0, {2'b00, code});
      3, 4: begin addByte(8'hF0, 0, 0, 0); addByte(code, 1, 0, {2'b01, code}); end
      5: begin addByte(8'hE0, 0, 0, 0); addByte(code, 1, 0, {2'b10, code}); end
      6: begin
        addByte(8'hE0, 0, 0, 0); addByte(8'hF0, 0, 0, 0);
        addByte(code, 1, 0, {2'b11, code});
      end
      7: begin
        addByte(8'hE1, 0, 0, 0); addByte(8'h14, 0, 0, 0); addByte(8'h77, 0, 0, 0);
        addByte(8'hE1, 0, 0, 0); addByte(8'hF0, 0, 0, 0); addByte(8'h14, 0, 0, 0);
        addByte(8'hF0, 0, 0, 0); addByte(8'h77, 1, 1, 10'h0E1);
      end
      default: addByte(statusBytes[$urandom_range(0, 4)], 0, 0, 0);
    endcase
  endtask

  initial begin
    int firstErr;
    int pulses;
    int gap;
    int popPct;
    bit sawEvent;
    bit doPop;
    bit ovfSet;
    bit keep;
    streamT item;

    vecs[0] = '{1, '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{10'h01C, 10'h000}};
    vecs[1] = '{2, '{8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{10'h11C, 10'h000}};
    vecs[2] = '{2, '{8'hE0, 8'h75, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{10'h275, 10'h000}};
    vecs[3] = '{5, '{8'hAA, 8'hFA, 8'hE0, 8'hF0, 8'h75, 8'h00, 8'h00, 8'h00}, 1, '{10'h375, 10'h000}};
    vecs[4] = '{4, '{8'hFA, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{10'h000, 10'h000}};
    vecs[5] = '{8, '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1, '{10'h0E1, 10'h000}};
    vecs[6] = '{4, '{8'h5A, 8'hE0, 8'hF0, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00}, 2, '{10'h05A, 10'h37C}};
    vecs[7] = '{3, '{8'hE0, 8'hE0, 8'h29, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, '{10'h2E0, 10'h029}};

    doReset();
    checkOutput("rst_valid", evValid, 0);
    checkOutput("rst_code", evCode, 0);
    checkOutput("rst_ext", evExt, 0);
    checkOutput("rst_brk", evBrk, 0);
    checkOutput("rst_full", fifoFull, 0);
    checkOutput("rst_ovf", ovfOut, 0);
    checkOutput("rst_seqerr", seqErr, 0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].nBytes; i++) sendByte(vecs[v].bytes[i]);
      for (int e = 0; e < vecs[v].nEv; e++)
        popExpect($sformatf("vec%0d_ev%0d", v, e), vecs[v].evs[e]);
      checkOutput($sformatf("vec%0d_empty", v), evValid, 0);
    end

    // Push latency: event visible right after the edge that samples the byte
    doReset();
    rxDone = 1'b1;
    rxByte = 8'h1C;
    #1;
    checkOutput("lat_before_edge", evValid, 0);
    tick();
    rxDone = 1'b0;
    checkOutput("lat_after_edge", evValid, 1);
    checkOutput("lat_head", {evExt, evBrk, evCode}, 10'h01C);
    sendByte(8'hF0);
    sendByte(8'h1C);
    popExpect("lat_pop0", 10'h01C);
    popExpect("lat_pop1", 10'h11C);
    checkOutput("lat_empty", evValid, 0);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checkOutput("pop_empty_ignored", evValid, 0);

    // Overflow, simultaneous push/pop at full, and ovf clearing
    doReset();
    for (int i = 0; i <= DEPTH; i++) sendByte(8'h10 + 8'(i));
    checkOutput("ovf_full", fifoFull, 1);
    checkOutput("ovf_set", ovfOut, 1);
    applyStimulus(8'h30, 1'b1);
    checkOutput("ovf_pp_full", fifoFull, 1);
    checkOutput("ovf_pp_ovf", ovfOut, 1);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    checkOutput("ovf_cleared", ovfOut, 0);
    applyStimulus(8'h31, 1'b1);
    checkOutput("ovf_pp2_full", fifoFull, 1);
    checkOutput("ovf_pp2_noset", ovfOut, 0);
    applyStimulus(8'h32, 1'b0);
    clrOvf = 1'b1;
    applyStimulus(8'h33, 1'b0);
    clrOvf = 1'b0;
    checkOutput("ovf_set_beats_clr", ovfOut, 1);
    for (int i = 0; i < 6; i++) popExpect($sformatf("ovf_drain%0d", i), 10'h012 + 10'(i));
    popExpect("ovf_drain6", 10'h030);
    popExpect("ovf_drain7", 10'h031);
    checkOutput("ovf_drained", evValid, 0);
    checkOutput("ovf_not_full", fifoFull, 0);

    // Timeout of a dangling break prefix
    doReset();
    sendByte(8'hF0);
    firstErr = -1;
    pulses   = 0;
    sawEvent = 1'b0;
    for (int i = 3; i <= TIMEOUT_CYC + 10; i++) begin
      tick();
      if (seqErr === 1'b1) begin
        pulses++;
        if (firstErr < 0) firstErr = i;
      end
      if (evValid !== 1'b0) sawEvent = 1'b1;
    end
    checkOutput("tmo_pulses", pulses, 1);
    checkOutput("tmo_cycle", firstErr, TIMEOUT_CYC);
    checkOutput("tmo_no_event", sawEvent, 0);
    sendByte(8'h1C);
    popExpect("tmo_after", 10'h01C);
    checkOutput("tmo_after_empty", evValid, 0);

    // Auto-repeat handling
    doReset();
    if (FILTER_EN) typExp = '{10'h01C, 10'h11C, 10'h01C};
    else typExp = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
    sendByte(8'h1C); sendByte(8'h1C); sendByte(8'h1C);
    sendByte(8'hF0); sendByte(8'h1C); sendByte(8'h1C);
    foreach (typExp[i]) popExpect($sformatf("typ_ev%0d", i), typExp[i]);
    checkOutput("typ_count", evValid, 0);

    // Reset in the middle of an extended sequence with a queued event
    doReset();
    sendByte(8'h1C);
    sendByte(8'hE0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_valid", evValid, 0);
    checkOutput("midrst_full", fifoFull, 0);
    sendByte(8'h75);
    popExpect("midrst_idle", 10'h075);
    checkOutput("midrst_empty", evValid, 0);

    // Randomized stream against the queue model
    doReset();
    for (int k = 0; k < 80; k++) addItem();
    gap = 0;
    for (int cyc = 0; cyc < 4000 && (stream.size() > 0 || modelQ.size() > 0); cyc++) begin
      checkOutput("rnd_valid", evValid, (modelQ.size() > 0) ? 1 : 0);
      checkOutput("rnd_head", {evExt, evBrk, evCode}, (modelQ.size() > 0) ? modelQ[0] : 10'h000);
      checkOutput("rnd_full", fifoFull, (modelQ.size() == DEPTH) ? 1 : 0);
      checkOutput("rnd_ovf", ovfOut, modelOvf);
      checkOutput("rnd_seqerr", seqErr, 0);
      item.hasEv = 1'b0;
      rxDone = 1'b0;
      if (gap > 0) begin
        gap--;
      end else if (stream.size() > 0) begin
        item   = stream.pop_front();
        rxDone = 1'b1;
        rxByte = item.b;
        gap    = $urandom_range(0, 3);
      end
      popPct = (cyc < 300) ? 10 : 50;
      rdEn   = ($urandom_range(0, 99) < popPct);
      clrOvf = ($urandom_range(0, 99) < 4);
      doPop  = rdEn && (modelQ.size() > 0);
      if (doPop) void'(modelQ.pop_front());
      ovfSet = 1'b0;
      if (rxDone && item.hasEv) begin
        modelFilter(item.ev, item.pause, keep);
        if (keep) begin
          if (modelQ.size() < DEPTH) modelQ.push_back(item.ev);
          else ovfSet = 1'b1;
        end
      end
      if (ovfSet) modelOvf = 1'b1;
      else if (clrOvf) modelOvf = 1'b0;
      tick();
    end
    rxDone = 1'b0;
    rdEn   = 1'b0;
    clrOvf = 1'b0;
    checkOutput("rnd_end_empty", evValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
